// File: rtl/key_candidate_gen.sv
// Candidate-key producer for the password search path: enumerates a contiguous index range,
// issues one key per handshake and stops on the first reported match.
module key_candidate_gen #(
    parameter int unsigned KEY_W = 128,
    parameter int unsigned IDX_W = 40
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             start,
    input  logic [KEY_W-1:0] baseKey,
    input  logic [IDX_W-1:0] startIdx,
    input  logic [IDX_W-1:0] lastIdx,
    output logic [KEY_W-1:0] candKey,
    output logic             candValid,
    input  logic             candReady,
    input  logic             foundValid,
    input  logic [KEY_W-1:0] foundKey,
    output logic             busy,
    output logic             done,
    output logic             success,
    output logic [KEY_W-1:0] resultKey,
    output logic [IDX_W:0]   issuedCount
);

    localparam int unsigned BASE_W = KEY_W - IDX_W;

    typedef enum logic [1:0] {
        StIdle      = 2'd0,
        StRun       = 2'd1,
        StFound     = 2'd2,
        StExhausted = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [BASE_W-1:0]   base_q, base_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [IDX_W-1:0]    last_q, last_d;
    logic [IDX_W:0]      issued_q, issued_d;
    logic [KEY_W-1:0]    result_q, result_d;

    logic                xfer;

    assign xfer = (state_q == StRun) && candReady;

    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        idx_d    = idx_q;
        last_d   = last_q;
        issued_d = issued_q;
        result_d = result_q;

        unique case (state_q)
            StIdle, StFound, StExhausted: begin
                if (start) begin
                    base_d   = baseKey[KEY_W-1:IDX_W];
                    idx_d    = startIdx;
                    last_d   = lastIdx;
                    issued_d = '0;
                    result_d = '0;
                    state_d  = (startIdx <= lastIdx) ? StRun : StExhausted;
                end else if (foundValid && (state_q == StExhausted)) begin
                    // Late hit from keys still in flight when the range ran out.
                    state_d  = StFound;
                    result_d = foundKey;
                end
            end
            StRun: begin
                if (xfer) begin
                    issued_d = issued_q + {{IDX_W{1'b0}}, 1'b1};
                    // Compare before incrementing so an all-ones last index never wraps.
                    if (idx_q == last_q) begin
                        state_d = StExhausted;
                    end else begin
                        idx_d = idx_q + {{(IDX_W-1){1'b0}}, 1'b1};
                    end
                end
                if (foundValid) begin
                    state_d  = StFound;
                    result_d = foundKey;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            base_q   <= '0;
            idx_q    <= '0;
            last_q   <= '0;
            issued_q <= '0;
            result_q <= '0;
        end else if (ena) begin
            state_q  <= state_d;
            base_q   <= base_d;
            idx_q    <= idx_d;
            last_q   <= last_d;
            issued_q <= issued_d;
            result_q <= result_d;
        end
    end

    assign candKey     = {base_q, idx_q};
    assign candValid   = (state_q == StRun);
    assign busy        = (state_q == StRun);
    assign done        = (state_q == StFound) || (state_q == StExhausted);
    assign success     = (state_q == StFound);
    assign resultKey   = result_q;
    assign issuedCount = issued_q;

endmodule

// File: tb/tb_key_candidate_gen.sv
// Directed self-checking bench for key_candidate_gen.
module tb_key_candidate_gen;

    localparam int KEY_W = 128;
    localparam int IDX_W = 40;

    logic             clk = 1'b0;
    logic             rst;
    logic             ena;
    logic             start;
    logic [KEY_W-1:0] baseKey;
    logic [IDX_W-1:0] startIdx;
    logic [IDX_W-1:0] lastIdx;
    logic [KEY_W-1:0] candKey;
    logic             candValid;
    logic             candReady;
    logic             foundValid;
    logic [KEY_W-1:0] foundKey;
    logic             busy;
    logic             done;
    logic             success;
    logic [KEY_W-1:0] resultKey;
    logic [IDX_W:0]   issuedCount;

    int tests = 0;
    int fails = 0;

    localparam logic [KEY_W-1:0] BASE  = 128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0;
    localparam logic [KEY_W-1:0] BASE2 = 128'h01020304_05060708_090A0B0C_0D0E0F10;
    localparam logic [KEY_W-1:0] K2A   = 128'h11112222_33334444_55556666_0000002A;
    localparam logic [KEY_W-1:0] KOTH  = 128'h99999999_99999999_99999999_99999999;
    localparam logic [KEY_W-1:0] KA    = 128'hAAAAAAAA_00000000_00000000_000000AA;
    localparam logic [KEY_W-1:0] KB    = 128'hBBBBBBBB_00000000_00000000_000000BB;
    localparam logic [KEY_W-1:0] KC    = 128'hCCCCCCCC_00000000_00000000_000000CC;
    localparam logic [IDX_W-1:0] ONES  = '1;

    key_candidate_gen #(.KEY_W(KEY_W), .IDX_W(IDX_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .start      (start),
        .baseKey    (baseKey),
        .startIdx   (startIdx),
        .lastIdx    (lastIdx),
        .candKey    (candKey),
        .candValid  (candValid),
        .candReady  (candReady),
        .foundValid (foundValid),
        .foundKey   (foundKey),
        .busy       (busy),
        .done       (done),
        .success    (success),
        .resultKey  (resultKey),
        .issuedCount(issuedCount)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [KEY_W-1:0] got,
                         input logic [KEY_W-1:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [KEY_W-1:0] mk(input logic [KEY_W-1:0] b,
                                            input logic [IDX_W-1:0] i);
        return {b[KEY_W-1:IDX_W], i};
    endfunction

    // Advance one rising edge, then settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [IDX_W-1:0] s, input logic [IDX_W-1:0] l);
        startIdx = s;
        lastIdx  = l;
        start    = 1'b1;
        step();
        start    = 1'b0;
    endtask

    int          exp_idx;
    logic [6:0]  ready_pat;

    initial begin
        rst = 1'b1; ena = 1'b1; start = 1'b0; baseKey = BASE;
        startIdx = '0; lastIdx = '0; candReady = 1'b0;
        foundValid = 1'b0; foundKey = '0;
        #1;
        check("rst_busy", {127'b0, busy}, 128'd0);
        check("rst_done", {127'b0, done}, 128'd0);
        check("rst_success", {127'b0, success}, 128'd0);
        check("rst_valid", {127'b0, candValid}, 128'd0);
        check("rst_result", resultKey, 128'd0);
        check("rst_issued", {87'b0, issuedCount}, 128'd0);
        step(); step();
        rst = 1'b0;
        step();

        // Exhaust 5..8 with continuous ready
        candReady = 1'b1;
        do_start(40'd5, 40'd8);
        for (int i = 5; i <= 8; i++) begin
            check("exh_valid", {127'b0, candValid}, 128'd1);
            check($sformatf("exh_key%0d", i), candKey, mk(BASE, i[IDX_W-1:0]));
            step();
        end
        check("exh_done", {127'b0, done}, 128'd1);
        check("exh_success", {127'b0, success}, 128'd0);
        check("exh_busy", {127'b0, busy}, 128'd0);
        check("exh_valid_end", {127'b0, candValid}, 128'd0);
        check("exh_issued", {87'b0, issuedCount}, 128'd4);

        // Backpressure: ready pattern (cycle 0 first) 1,0,0,1,0,1,1
        ready_pat = 7'b1101001;
        candReady = 1'b0;
        do_start(40'd5, 40'd8);
        exp_idx = 5;
        for (int c = 0; c < 7; c++) begin
            check($sformatf("bp_key_c%0d", c), candKey, mk(BASE, exp_idx[IDX_W-1:0]));
            candReady = ready_pat[c];
            step();
            if (ready_pat[c]) exp_idx++;
        end
        check("bp_done", {127'b0, done}, 128'd1);
        check("bp_issued", {87'b0, issuedCount}, 128'd4);

        // Hit after third transfer
        candReady = 1'b1;
        do_start(40'd10, 40'd20);
        step(); step(); step();
        check("hit_pre_key", candKey, mk(BASE, 40'd13));
        candReady  = 1'b0;
        foundValid = 1'b1;
        foundKey   = K2A;
        step();
        foundValid = 1'b0;
        check("hit_success", {127'b0, success}, 128'd1);
        check("hit_done", {127'b0, done}, 128'd1);
        check("hit_valid", {127'b0, candValid}, 128'd0);
        check("hit_result", resultKey, K2A);
        check("hit_issued", {87'b0, issuedCount}, 128'd3);
        foundValid = 1'b1;
        foundKey   = KOTH;
        step();
        foundValid = 1'b0;
        check("hit_held", resultKey, K2A);
        check("hit_held_succ", {127'b0, success}, 128'd1);

        // Boundary: all-ones last index, no wrap
        candReady = 1'b1;
        do_start(ONES - 40'd1, ONES);
        check("bnd_key0", candKey, mk(BASE, ONES - 40'd1));
        step();
        check("bnd_key1", candKey, mk(BASE, ONES));
        check("bnd_valid1", {127'b0, candValid}, 128'd1);
        step();
        check("bnd_done", {127'b0, done}, 128'd1);
        check("bnd_valid_end", {127'b0, candValid}, 128'd0);
        check("bnd_issued", {87'b0, issuedCount}, 128'd2);

        // Empty range
        do_start(40'd9, 40'd3);
        check("empty_done", {127'b0, done}, 128'd1);
        check("empty_busy", {127'b0, busy}, 128'd0);
        check("empty_success", {127'b0, success}, 128'd0);
        check("empty_issued", {87'b0, issuedCount}, 128'd0);

        // Found coincident with final transfer
        do_start(40'd0, 40'd2);
        step(); step();
        foundValid = 1'b1;
        foundKey   = KA;
        step();
        foundValid = 1'b0;
        check("sim_success", {127'b0, success}, 128'd1);
        check("sim_result", resultKey, KA);
        check("sim_issued", {87'b0, issuedCount}, 128'd3);

        // Late hit while exhausted
        do_start(40'd0, 40'd1);
        step(); step();
        check("late_pre_succ", {127'b0, success}, 128'd0);
        check("late_pre_done", {127'b0, done}, 128'd1);
        foundValid = 1'b1;
        foundKey   = KB;
        step();
        foundValid = 1'b0;
        check("late_success", {127'b0, success}, 128'd1);
        check("late_result", resultKey, KB);

        // Start together with found in FOUND: start wins
        foundValid = 1'b1;
        foundKey   = KC;
        do_start(40'd100, 40'd110);
        foundValid = 1'b0;
        check("sf_busy", {127'b0, busy}, 128'd1);
        check("sf_success", {127'b0, success}, 128'd0);
        check("sf_result", resultKey, 128'd0);
        check("sf_key", candKey, mk(BASE, 40'd100));
        step();
        check("ena_pre_key", candKey, mk(BASE, 40'd101));

        // ena low freezes everything for 3 cycles
        ena = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            check($sformatf("ena_hold_key%0d", c), candKey, mk(BASE, 40'd101));
            check($sformatf("ena_hold_cnt%0d", c), {87'b0, issuedCount}, 128'd1);
        end
        ena = 1'b1;
        step();
        check("ena_resume_key", candKey, mk(BASE, 40'd102));
        check("ena_resume_cnt", {87'b0, issuedCount}, 128'd2);

        // Start during RUN ignored (new base/range must not load)
        baseKey = BASE2;
        do_start(40'd0, 40'd0);
        baseKey = BASE;
        check("run_start_key", candKey, mk(BASE, 40'd103));
        check("run_start_busy", {127'b0, busy}, 128'd1);

        // Asynchronous reset mid-run
        #2 rst = 1'b1;
        #1;
        check("arst_busy", {127'b0, busy}, 128'd0);
        check("arst_valid", {127'b0, candValid}, 128'd0);
        check("arst_issued", {87'b0, issuedCount}, 128'd0);
        check("arst_key", candKey, 128'd0);
        step();
        rst = 1'b0;
        step();
        check("arst_idle_busy", {127'b0, busy}, 128'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
